// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width and ID/EX control-vector layout.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 11;

  // Bit positions inside the 11-bit decoded control vector
  localparam int CTRL_REGW    = 10;
  localparam int CTRL_MEMR    = 9;
  localparam int CTRL_MEMW    = 8;
  localparam int CTRL_MEM2REG = 7;
  localparam int CTRL_ALUSRC  = 6;
  localparam int CTRL_BRANCH  = 5;
  localparam int CTRL_JUMP    = 4;
  localparam int CTRL_ALUOP_H = 3;
  localparam int CTRL_ALUOP_L = 2;
  localparam int CTRL_F7B5    = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on synchronous reset, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying events, never wrapping past the maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, branch flush and
// saturating bubble/flush event counters for performance debug.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              block_control,
  input  logic              ID_EX_Write,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [2:0]        id_funct3,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ID_EX_RegRd,
  output logic              ID_EX_MemR,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [2:0]        ex_funct3,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic bubble_inc;

  // A bubble only counts when a flush is not overriding it on the same edge
  assign bubble_inc = block_control & ~flush;

  // MemRead is taken straight from the registered control vector so the two can never disagree
  assign ID_EX_MemR = ex_ctrl[CTRL_MEMR];

  // Stage register update: rst > flush > block_control > ID_EX_Write > hold
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ID_EX_RegRd <= '0;
      ex_ctrl     <= '0;
      ex_funct3   <= '0;
    end else if (block_control) begin
      // Bubble: kill control and destination only, data fields keep their values
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ID_EX_RegRd <= '0;
    end else if (ID_EX_Write) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ID_EX_RegRd <= id_rd;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_funct3   <= id_funct3;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, randomized
// traffic against a behavioural model, and counter saturation/reset sequences.
module tb_id_ex_stage_reg;

  localparam int XL      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst, block_control, ID_EX_Write, flush, id_valid;
  logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [10:0]   id_ctrl;
  logic [2:0]    id_funct3;

  logic          ex_valid, ID_EX_MemR;
  logic [XL-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ID_EX_RegRd;
  logic [10:0]   ex_ctrl;
  logic [2:0]    ex_funct3;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  id_ex_stage_reg #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .block_control(block_control), .ID_EX_Write(ID_EX_Write),
    .flush(flush), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_ctrl(id_ctrl), .id_funct3(id_funct3), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ID_EX_RegRd(ID_EX_RegRd),
    .ID_EX_MemR(ID_EX_MemR), .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the EX stage should hold, as a record of fields
  typedef struct {
    logic          valid;
    logic [XL-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]    rs1, rs2, rd;
    logic [10:0]   ctrl;
    logic [2:0]    f3;
    int            bub, fl;
  } ex_state_t;

  ex_state_t m;

  function automatic int sat_inc(input int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  function automatic ex_state_t zero_state();
    ex_state_t z;
    z.valid = 1'b0; z.pc = '0; z.rs1d = '0; z.rs2d = '0; z.imm = '0;
    z.rs1 = '0; z.rs2 = '0; z.rd = '0; z.ctrl = '0; z.f3 = '0;
    z.bub = 0; z.fl = 0;
    return z;
  endfunction

  // Apply one edge of the stage's rules to the model using the driven inputs
  task automatic model_edge();
    ex_state_t n;
    n = m;
    if (rst) begin
      n = zero_state();
    end else if (flush) begin
      n = zero_state();
      n.bub = m.bub;
      n.fl  = sat_inc(m.fl);
    end else if (block_control) begin
      n.valid = 1'b0;
      n.ctrl  = '0;
      n.rd    = '0;
      n.bub   = sat_inc(m.bub);
    end else if (ID_EX_Write) begin
      n.valid = id_valid;
      n.pc = id_pc; n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.imm = id_imm;
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.f3 = id_funct3;
      n.ctrl = id_valid ? id_ctrl : 11'h000;
    end
    m = n;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ex_valid"},    64'(ex_valid),    64'(m.valid));
    check({tag, ".ex_pc"},       64'(ex_pc),       64'(m.pc));
    check({tag, ".ex_rs1_data"}, 64'(ex_rs1_data), 64'(m.rs1d));
    check({tag, ".ex_rs2_data"}, 64'(ex_rs2_data), 64'(m.rs2d));
    check({tag, ".ex_imm"},      64'(ex_imm),      64'(m.imm));
    check({tag, ".ex_rs1"},      64'(ex_rs1),      64'(m.rs1));
    check({tag, ".ex_rs2"},      64'(ex_rs2),      64'(m.rs2));
    check({tag, ".RegRd"},       64'(ID_EX_RegRd), 64'(m.rd));
    check({tag, ".ex_ctrl"},     64'(ex_ctrl),     64'(m.ctrl));
    check({tag, ".MemR"},        64'(ID_EX_MemR),  64'(m.ctrl[9]));
    check({tag, ".ex_funct3"},   64'(ex_funct3),   64'(m.f3));
    check({tag, ".bubble_cnt"},  64'(bubble_cnt),  64'(m.bub));
    check({tag, ".flush_cnt"},   64'(flush_cnt),   64'(m.fl));
  endtask

  task automatic randomize_data();
    id_valid    = 1'($urandom);
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_rs1      = 5'($urandom);
    id_rs2      = 5'($urandom);
    id_rd       = 5'($urandom);
    id_ctrl     = 11'($urandom);
    id_funct3   = 3'($urandom);
  endtask

  // Clock the design once, advance the model, and settle before sampling
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst, fl, bc, wr, vld;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [10:0] ctrl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic [10:0] e_ctrl;
    int          e_bub, e_fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic w,
                              input logic v, input logic [31:0] pc, input logic [4:0] rd,
                              input logic [10:0] c, input logic ev, input logic [31:0] epc,
                              input logic [4:0] erd, input logic [10:0] ec,
                              input int eb, input int ef);
    vec_t x;
    x.rst = r; x.fl = f; x.bc = b; x.wr = w; x.vld = v; x.pc = pc; x.rd = rd; x.ctrl = c;
    x.e_valid = ev; x.e_pc = epc; x.e_rd = erd; x.e_ctrl = ec; x.e_bub = eb; x.e_fl = ef;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m = zero_state();
    rst = 1'b1; flush = 1'b1; block_control = 1'b1; ID_EX_Write = 1'b1;
    randomize_data();

    //          rst fl bc wr vld  pc           rd ctrl    | valid pc        rd ctrl   bub fl
    vecs.push_back(mk(1, 1, 1, 1, 1, 32'h0000_dead, 7, 11'h7FF, 0, 32'h0,  0, 11'h000, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 32'h0000_beef, 7, 11'h7FF, 0, 32'h0,  0, 11'h000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_0040, 5, 11'h200, 1, 32'h40, 5, 11'h200, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h0000_0044, 6, 11'h400, 0, 32'h40, 0, 11'h000, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h0000_0048, 9, 11'h600, 0, 32'h0,  0, 11'h000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_0080, 3, 11'h4A4, 1, 32'h80, 3, 11'h4A4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0100, 1, 11'h7FF, 1, 32'h80, 3, 11'h4A4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0000_0104, 2, 11'h3FF, 1, 32'h80, 3, 11'h4A4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_0108, 4, 11'h000, 1, 32'h80, 3, 11'h4A4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0000_00C0, 4, 11'h7FE, 0, 32'hC0, 4, 11'h000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0000_00C4, 8, 11'h7FF, 0, 32'hC0, 0, 11'h000, 2, 1));

    // Directed vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      randomize_data();
      rst = vecs[i].rst; flush = vecs[i].fl; block_control = vecs[i].bc;
      ID_EX_Write = vecs[i].wr; id_valid = vecs[i].vld; id_pc = vecs[i].pc;
      id_rd = vecs[i].rd; id_ctrl = vecs[i].ctrl;
      tick();
      check($sformatf("vec%0d.ex_valid", i),   64'(ex_valid),    64'(vecs[i].e_valid));
      check($sformatf("vec%0d.ex_pc", i),      64'(ex_pc),       64'(vecs[i].e_pc));
      check($sformatf("vec%0d.RegRd", i),      64'(ID_EX_RegRd), 64'(vecs[i].e_rd));
      check($sformatf("vec%0d.ex_ctrl", i),    64'(ex_ctrl),     64'(vecs[i].e_ctrl));
      check($sformatf("vec%0d.MemR", i),       64'(ID_EX_MemR),  64'(vecs[i].e_ctrl[9]));
      check($sformatf("vec%0d.bubble_cnt", i), 64'(bubble_cnt),  64'(vecs[i].e_bub));
      check($sformatf("vec%0d.flush_cnt", i),  64'(flush_cnt),   64'(vecs[i].e_fl));
      check_all($sformatf("vec%0d", i));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      randomize_data();
      rst           = ($urandom_range(0, 39) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      block_control = ($urandom_range(0, 5) == 0);
      ID_EX_Write   = ($urandom_range(0, 3) != 0);
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    // Bubble counter saturation with a mid-sequence reset
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; block_control = 1'b0; ID_EX_Write = 1'b0;
    tick();
    check("sat.reset_bub", 64'(bubble_cnt), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      randomize_data();
      rst = 1'b0; block_control = 1'b1; ID_EX_Write = 1'b0;
      tick();
      check($sformatf("sat.bub%0d", i), 64'(bubble_cnt), 64'((i < 15) ? i : 15));
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("sat.mid_rst_bub", 64'(bubble_cnt), 64'd0);
    check("sat.mid_rst_valid", 64'(ex_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("sat.recount_bub", 64'(bubble_cnt), 64'd1);
    check_all("sat.recount");

    // Flush counter saturation; bubbles requested alongside must not count
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      randomize_data();
      flush = 1'b1; block_control = 1'(i % 2); ID_EX_Write = 1'b1;
      tick();
      check($sformatf("sat.fl%0d", i), 64'(flush_cnt), 64'((i < 15) ? i : 15));
      check($sformatf("sat.fl_bub%0d", i), 64'(bubble_cnt), 64'd1);
    end
    check_all("sat.flush_end");

    // Reset asserted during a flush gives the reset state
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; block_control = 1'b1;
    tick();
    check_all("rst_in_flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
